// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings shared by the multiply/divide unit and the main decoder
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX} muldiv_state_t;
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction
  function automatic logic is_signed_op(input logic [2:0] op);
    return !op[0];
  endfunction
  function automatic logic is_div_op(input logic [2:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared adder/subtractor, 2*WIDTH shift register and sign fix
// Ports: clk, reset_n; load latches |a|, |b|, sign flags and mode from op;
// step advances one bit of shift-add multiply or restoring divide;
// res_hi/res_lo are the sign-corrected HI/LO results read during FIX.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  logic [2*WIDTH-1:0] acc, acc_n, prod_fix;
  logic [WIDTH-1:0]   bq, quo, rem;
  logic [WIDTH+1:0]   x, r;
  logic               sa, sb, div, sa_n, sb_n;
  always_comb begin
    sa_n = is_signed_op(op) & a[WIDTH-1];
    sb_n = is_signed_op(op) & b[WIDTH-1];
    // divide works on the remainder shifted left by one, multiply on the upper half
    x = div ? {1'b0, acc[2*WIDTH-1:WIDTH-1]} : {2'b0, acc[2*WIDTH-1:WIDTH]};
    r = div ? x - {2'b0, bq} : x + {2'b0, bq};
    acc_n = div ? (r[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} : {r[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                : (acc[0] ? {r[WIDTH:0], acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    prod_fix = (sa ^ sb) ? -acc : acc;
    // a zero divisor leaves the all-ones quotient untouched regardless of signs
    res_lo = div ? (((sa ^ sb) && bq != '0) ? -quo : quo) : prod_fix[WIDTH-1:0];
    res_hi = div ? (sa ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc <= '0;
      bq  <= '0;
      sa  <= 1'b0;
      sb  <= 1'b0;
      div <= 1'b0;
    end else if (load) begin
      sa  <= sa_n;
      sb  <= sb_n;
      div <= is_div_op(op);
      bq  <= sb_n ? -b : b;
      acc <= {{WIDTH{1'b0}}, sa_n ? -a : a};
    end else if (step)
      acc <= acc_n;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
// Ports: clk, reset_n (async, active-low); start/op/a/b issue an operation from IDLE;
// flush aborts to IDLE; busy while not IDLE; done pulses when a new result lands in hi/lo.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  muldiv_state_t    state;
  logic [CW-1:0]    cnt;
  logic             load, step;
  logic [WIDTH-1:0] res_hi, res_lo;
  assign load = state == IDLE && start && !flush && is_arith(op);
  assign step = state == CALC && !flush;
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .reset_n(reset_n), .load(load), .step(step), .op(op),
    .a(a), .b(b), .res_hi(res_hi), .res_lo(res_lo)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else
        case (state)
          IDLE:
            if (load) begin
              state <= CALC;
              cnt   <= '0;
              busy  <= 1'b1;
            end else if (start && op == OP_MTHI) hi <= a;
            else if (start && op == OP_MTLO) lo <= a;
          CALC: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int W = 32;
  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int n_cmp = 0, n_bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // returns {hi, lo} computed with plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 3'd0) return 64'(sx * sy);
    if (o == 3'd1) return {32'b0, x} * {32'b0, y};
    if (y == '0) return {x, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction

  // called just after a negedge; returns at the negedge of the done cycle
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] e;
    int lat;
    logic busy_ok;
    e = ref_result(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    check("done_low_c1", done, 0);
    check("hilo_hold_c1", {hi, lo}, {m_hi, m_lo});
    while (!done && lat < W + 10) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, W + 2);
    check("busy_held", busy_ok, 1);
    check("busy_at_done", busy, 0);
    check("result", {hi, lo}, e);
    if (done) begin m_hi = e[63:32]; m_lo = e[31:0]; end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      4: return -W'($urandom_range(1, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic saw_done;
    @(negedge clk);
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("tp_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("tp_multu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("tp_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd3, 32'd7, 32'd0);
    check("tp_divu0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("tp_divovf", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(3'd2, 32'hFFFF_FFF0, 32'd0);
    check("tp_div0_neg", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);

    repeat (40) do_op(3'($urandom_range(0, 3)), pick(), pick());

    op = 3'd4; a = 32'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, m_lo);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    m_hi = 32'h1234;

    op = 3'd5; a = 32'hCAFE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mtlo", {hi, lo}, {m_hi, 32'hCAFE});
    m_lo = 32'hCAFE;

    op = 3'd6; a = 32'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reserved", {hi, lo, 1'b0, busy}, {m_hi, m_lo, 2'b00});

    op = 3'd4; a = 32'h9999; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_mthi", hi, m_hi);

    op = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", saw_done, 0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});

    do_op(3'd1, 32'd12345, 32'd678);

    op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'h0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    do_op(3'd3, 32'd1000, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
